// File: rtl/tape_out_fifo_scheduler.sv
// tape_out_fifo_scheduler: queues decoder bytes into FIFO_out and injects a 3-byte marker on SAVE mode change.
// Optional TAPE_OUT_SCHED_DROPCNT_EN adds a saturating dropped-byte counter output o_drop_cnt.
module tape_out_fifo_scheduler #(
    parameter int         QDEPTH_LOG2 = 2,
    parameter logic [7:0] MARK_HI     = 8'hA5,
    parameter logic [7:0] MARK_LO     = 8'h5A
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [7:0] i_dec_data,
    input  logic       i_dec_wr,
    input  logic [1:0] i_save_mode_id,
    input  logic       i_fifo_afull,
    input  logic       i_ovf_clr,
    output logic [7:0] o_fifo_data,
    output logic       o_fifo_wr,
    output logic       o_overflow,
    output logic       o_busy
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
    ,
    output logic [7:0] o_drop_cnt
`endif
);
    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam int CW    = QDEPTH_LOG2 + 1;

    typedef enum logic [1:0] {S_RUN, S_MK_HI, S_MK_LO, S_MK_ID} state_t;

    state_t                 state_q;
    logic [7:0]             mem [DEPTH];
    logic [QDEPTH_LOG2-1:0] rd_ptr_q;
    logic [QDEPTH_LOG2-1:0] wr_ptr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          pre_cnt_q;
    logic [1:0]             mode_q;
    logic [1:0]             new_mode_q;
    logic                   pending_q;

    logic change, full, empty, go_mark, pop, push, drop;

    assign change  = i_save_mode_id != mode_q;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign go_mark = pending_q && pre_cnt_q == '0;
    assign pop     = state_q == S_RUN && !go_mark && !empty && !i_fifo_afull;
    assign push    = i_dec_wr && (!full || pop);
    assign drop    = i_dec_wr && full && !pop;

    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr_q] <= i_dec_data;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pre_cnt_q   <= '0;
            mode_q      <= 2'b00;
            new_mode_q  <= 2'b00;
            pending_q   <= 1'b0;
            o_fifo_data <= 8'h00;
            o_fifo_wr   <= 1'b0;
            o_overflow  <= 1'b0;
            o_busy      <= 1'b0;
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
            o_drop_cnt  <= 8'h00;
`endif
        end else begin
            mode_q     <= i_save_mode_id;
            o_fifo_wr  <= 1'b0;
            o_busy     <= !empty || pending_q || state_q != S_RUN;
            o_overflow <= drop | (o_overflow & ~i_ovf_clr);
            count_q    <= count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + QDEPTH_LOG2'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + QDEPTH_LOG2'(1);
            if (pending_q && pop) pre_cnt_q <= pre_cnt_q - CW'(1);
            case (state_q)
                S_RUN: begin
                    if (go_mark) begin
                        state_q <= S_MK_HI;
                    end else if (pop) begin
                        o_fifo_data <= mem[rd_ptr_q];
                        o_fifo_wr   <= 1'b1;
                    end
                end
                S_MK_HI: if (!i_fifo_afull) begin
                    o_fifo_data <= MARK_HI;
                    o_fifo_wr   <= 1'b1;
                    state_q     <= S_MK_LO;
                end
                S_MK_LO: if (!i_fifo_afull) begin
                    o_fifo_data <= MARK_LO;
                    o_fifo_wr   <= 1'b1;
                    state_q     <= S_MK_ID;
                end
                S_MK_ID: if (!i_fifo_afull) begin
                    o_fifo_data <= {6'b0, new_mode_q};
                    o_fifo_wr   <= 1'b1;
                    pending_q   <= 1'b0;
                    state_q     <= S_RUN;
                end
            endcase
            // A same-cycle pop is an old-mode byte already leaving, so it is not counted.
            if (change) begin
                pending_q  <= 1'b1;
                new_mode_q <= i_save_mode_id;
                if (!pending_q) pre_cnt_q <= count_q - CW'(pop);
                else if (state_q != S_RUN) state_q <= S_MK_HI;
            end
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
            if (i_ovf_clr) o_drop_cnt <= {7'b0, drop};
            else if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
`endif
        end
    end
endmodule

// File: tb/tb_tape_out_fifo_scheduler.sv
// tb_tape_out_fifo_scheduler: directed scenarios plus randomized run against a queue-based reference model.
module tb_tape_out_fifo_scheduler;
    localparam logic [7:0] MK_HI = 8'hA5;
    localparam logic [7:0] MK_LO = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] dec_data = 8'h00;
    logic       dec_wr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       afull = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_wr;
    logic       ovf;
    logic       busy;
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] got [$];

    logic [7:0] m_q [$];
    bit         m_pend, m_ovf, e_wr;
    int         m_pre, m_phase, m_dcnt;
    logic [1:0] m_mode, m_new;
    logic [7:0] e_data;

    always #5 clk = ~clk;

    tape_out_fifo_scheduler dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_dec_data    (dec_data),
        .i_dec_wr      (dec_wr),
        .i_save_mode_id(mode),
        .i_fifo_afull  (afull),
        .i_ovf_clr     (clr),
        .o_fifo_data   (fifo_data),
        .o_fifo_wr     (fifo_wr),
        .o_overflow    (ovf),
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
        .o_drop_cnt    (drop_cnt),
`endif
        .o_busy        (busy)
    );

    always @(negedge clk) if (fifo_wr === 1'b1) got.push_back(fifo_data);

    function automatic logic [63:0] pack_got();
        logic [63:0] r = '0;
        foreach (got[i]) r = {r[55:0], got[i]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dec_wr = 0; afull = 0; clr = 0; mode = 0;
        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        tick();
        got.delete();
        m_q.delete();
        m_pend = 0; m_ovf = 0; m_pre = 0; m_phase = 0; m_dcnt = 0; m_mode = 0; m_new = 0;
    endtask

    // Expected output stream derived from the byte queue and marker sequencing rules.
    task automatic model_step();
        bit was_pend, chg, drop;
        int was_phase;
        was_pend = m_pend; was_phase = m_phase; chg = mode != m_mode;
        e_wr = 0;
        if (m_phase == 0) begin
            if (m_pend && m_pre == 0) m_phase = 1;
            else if (m_q.size() != 0 && !afull) begin
                e_data = m_q.pop_front(); e_wr = 1;
                if (m_pend) m_pre--;
            end
        end else if (!afull) begin
            e_data = m_phase == 1 ? MK_HI : m_phase == 2 ? MK_LO : {6'b0, m_new};
            e_wr = 1;
            if (m_phase == 3) begin m_phase = 0; m_pend = 0; end
            else m_phase++;
        end
        if (chg) begin
            if (!was_pend) m_pre = m_q.size();
            else if (was_phase != 0) m_phase = 1;
            m_pend = 1; m_new = mode;
        end
        m_mode = mode;
        drop = dec_wr && m_q.size() == 4;
        if (dec_wr && !drop) m_q.push_back(dec_data);
        m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
        m_dcnt = clr ? int'(drop) : (drop && m_dcnt < 255) ? m_dcnt + 1 : m_dcnt;
    endtask

    task automatic test_reset();
        rst_n = 1; #2; rst_n = 0; #1;
        n_checks++; if (fifo_wr !== 1'b0) $display("FAIL reset_wr got=%b exp=0", fifo_wr); else n_pass++;
        n_checks++; if (fifo_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", fifo_data); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        @(negedge clk) rst_n = 1;
        got.delete();
        repeat (5) tick();
        n_checks++; if (got.size() != 0 || busy !== 1'b0) $display("FAIL reset_idle writes=%0d busy=%b exp 0/0", got.size(), busy); else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        dec_data = 8'h3C; dec_wr = 1; tick(); dec_wr = 0;
        n_checks++; if (fifo_wr !== 1'b0) $display("FAIL lat_n1 wr got=%b exp=0", fifo_wr); else n_pass++;
        tick();
        n_checks++; if (fifo_wr !== 1'b1 || fifo_data !== 8'h3C) $display("FAIL lat_n2 wr=%b data=%h exp 1/3c", fifo_wr, fifo_data); else n_pass++;
        tick();
        n_checks++; if (fifo_wr !== 1'b0) $display("FAIL lat_n3 wr got=%b exp=0", fifo_wr); else n_pass++;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL lat_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        afull = 1;
        for (int i = 0; i < 6; i++) begin
            dec_wr = 1; dec_data = 8'h10 + 8'(i); tick();
            if (i == 3) begin
                n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_before got=%b exp=0", ovf); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_after5 got=%b exp=1", ovf); else n_pass++;
            end
        end
        dec_wr = 0; tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL ovf_busy got=%b exp=1", busy); else n_pass++;
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
        n_checks++; if (drop_cnt !== 8'd2) $display("FAIL dcnt_two got=%0d exp=2", drop_cnt); else n_pass++;
`endif
        clr = 1; dec_wr = 1; dec_data = 8'h77; tick(); clr = 0; dec_wr = 0;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set_beats_clr got=%b exp=1", ovf); else n_pass++;
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
        n_checks++; if (drop_cnt !== 8'd1) $display("FAIL dcnt_clr_drop got=%0d exp=1", drop_cnt); else n_pass++;
`endif
        got.delete();
        afull = 0;
        repeat (8) tick();
        n_checks++; if (got.size() != 4 || pack_got() !== 64'h10111213) $display("FAIL ovf_drain n=%0d got=%h exp n=4 10111213", got.size(), pack_got()); else n_pass++;
        clr = 1; tick(); clr = 0;
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf); else n_pass++;
    endtask

    task automatic test_mode_order();
        do_reset();
        afull = 1;
        for (int i = 0; i < 3; i++) begin dec_wr = 1; dec_data = 8'h21 + 8'(i); tick(); end
        dec_wr = 0; mode = 1; tick();
        afull = 0;
        dec_wr = 1; dec_data = 8'h31; tick();
        dec_data = 8'h32; tick();
        dec_wr = 0;
        repeat (12) tick();
        n_checks++; if (got.size() != 8 || pack_got() !== 64'h212223A55A013132) $display("FAIL mode_order n=%0d got=%h exp n=8 212223a55a013132", got.size(), pack_got()); else n_pass++;
    endtask

    task automatic test_marker_restart();
        bit seen = 0;
        do_reset();
        mode = 2;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = fifo_wr === 1'b1 && fifo_data === MK_HI;
        end
        n_checks++; if (!seen) $display("FAIL restart_first_hi timeout got=none exp=a5"); else n_pass++;
        mode = 3;
        repeat (10) tick();
        n_checks++; if (got.size() != 5 || pack_got() !== 64'hA55AA55A03) $display("FAIL restart_seq n=%0d got=%h exp n=5 a55aa55a03", got.size(), pack_got()); else n_pass++;
    endtask

    task automatic test_afull_toggle();
        int viol = 0;
        bit a;
        do_reset();
        mode = 1;
        for (int i = 0; i < 20; i++) begin
            afull = (i % 2) == 0;
            a = afull;
            tick();
            if (fifo_wr === 1'b1 && a) viol++;
        end
        afull = 0;
        n_checks++; if (viol != 0) $display("FAIL toggle_afull_issue got=%0d exp=0", viol); else n_pass++;
        n_checks++; if (got.size() != 3 || pack_got() !== 64'hA55A01) $display("FAIL toggle_seq n=%0d got=%h exp n=3 a55a01", got.size(), pack_got()); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1;
        dec_wr = 1; dec_data = 8'h41; tick();
        dec_data = 8'h42; tick();
        dec_wr = 0; tick();
        #2 rst_n = 0; #1;
        n_checks++; if (fifo_wr !== 1'b0 || fifo_data !== 8'h00 || busy !== 1'b0 || ovf !== 1'b0)
            $display("FAIL async_rst wr=%b data=%h busy=%b ovf=%b exp all 0", fifo_wr, fifo_data, busy, ovf); else n_pass++;
        mode = 0;
        got.delete();
        @(negedge clk) rst_n = 1;
        repeat (10) tick();
        n_checks++; if (got.size() != 0 || busy !== 1'b0) $display("FAIL async_rst_quiet writes=%0d busy=%b exp 0/0", got.size(), busy); else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            dec_wr = 1'($urandom_range(0, 1));
            dec_data = 8'($urandom);
            afull = $urandom_range(0, 99) < 40;
            clr = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            model_step();
            tick();
            n_checks++;
            if (fifo_wr !== e_wr || (e_wr && fifo_data !== e_data) || ovf !== m_ovf) begin
                if (bad < 10) $display("FAIL rand_cycle%0d wr=%b data=%h ovf=%b exp wr=%b data=%h ovf=%b", c, fifo_wr, fifo_data, ovf, e_wr, e_data, m_ovf);
                bad++;
            end else n_pass++;
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
            n_checks++; if (drop_cnt !== 8'(m_dcnt)) $display("FAIL rand_dcnt%0d got=%0d exp=%0d", c, drop_cnt, m_dcnt); else n_pass++;
`endif
        end
        dec_wr = 0; clr = 0; afull = 0;
    endtask

`ifdef TAPE_OUT_SCHED_DROPCNT_EN
    task automatic test_drop_cnt();
        do_reset();
        afull = 1; dec_wr = 1; dec_data = 8'h99;
        repeat (304) tick();
        dec_wr = 0; tick();
        n_checks++; if (drop_cnt !== 8'hFF) $display("FAIL dcnt_sat got=%h exp=ff", drop_cnt); else n_pass++;
        clr = 1; tick(); clr = 0;
        n_checks++; if (drop_cnt !== 8'h00) $display("FAIL dcnt_clr got=%h exp=00", drop_cnt); else n_pass++;
        afull = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_mode_order();
        test_marker_restart();
        test_afull_toggle();
        test_async_reset();
        test_random();
`ifdef TAPE_OUT_SCHED_DROPCNT_EN
        test_drop_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
